// File: rtl/programmable_tick_gen.sv
// Multi-channel programmable timebase: each channel divides the system clock by a
// run-time divisor and emits a one-cycle tick enable plus a 50% square wave.
module programmable_tick_gen #(
   parameter int CHANNELS   = 4,
   parameter int WIDTH      = 26,
   parameter int FREE_WIDTH = 32,
   parameter int CHAN_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  cfg_we,
   input  logic [CHAN_BITS-1:0]  cfg_chan,
   input  logic [WIDTH-1:0]      cfg_div,
   input  logic                  cfg_oneshot,
   output logic [CHANNELS-1:0]   tick,
   output logic [CHANNELS-1:0]   square,
   output logic [CHANNELS-1:0]   running,
   output logic [FREE_WIDTH-1:0] free_count
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} chan_state_t;

   logic [FREE_WIDTH-1:0] free_r;

   // Legacy free-running tap; freezes together with the channels when enable is low.
   always_ff @(posedge clock) begin
      if (reset) begin
         free_r <= '0;
      end else if (enable) begin
         free_r <= free_r + FREE_WIDTH'(1);
      end
   end

   assign free_count = free_r;

   for (genvar k = 0; k < CHANNELS; k++) begin : gChan
      chan_state_t      state, state_next;
      logic [WIDTH-1:0] count, count_next;
      logic [WIDTH-1:0] div, div_next;
      logic             oneshot, oneshot_next;
      logic             tick_r, tick_next;
      logic             square_r, square_next;
      logic             wr;

      // Addresses at or beyond CHANNELS never match any k, so such writes fall away.
      assign wr = cfg_we && (cfg_chan == CHAN_BITS'(k));

      // A write always wins over the terminal count, so a restart never emits a stray tick.
      always_comb begin
         state_next   = state;
         count_next   = count;
         div_next     = div;
         oneshot_next = oneshot;
         tick_next    = 1'b0;
         square_next  = square_r;
         if (wr) begin
            div_next     = cfg_div;
            oneshot_next = cfg_oneshot;
            count_next   = cfg_div - WIDTH'(1);
            square_next  = 1'b0;
            state_next   = (cfg_div != '0) ? RUN : IDLE;
         end else if (enable && (state == RUN)) begin
            if (count != '0) begin
               count_next = count - WIDTH'(1);
            end else begin
               tick_next   = 1'b1;
               square_next = ~square_r;
               if (oneshot) begin
                  state_next = DONE;
               end else begin
                  count_next = div - WIDTH'(1);
               end
            end
         end
      end

      always_ff @(posedge clock) begin
         if (reset) begin
            state    <= IDLE;
            count    <= '0;
            div      <= '0;
            oneshot  <= 1'b0;
            tick_r   <= 1'b0;
            square_r <= 1'b0;
         end else begin
            state    <= state_next;
            count    <= count_next;
            div      <= div_next;
            oneshot  <= oneshot_next;
            tick_r   <= tick_next;
            square_r <= square_next;
         end
      end

      assign tick[k]    = tick_r;
      assign square[k]  = square_r;
      assign running[k] = (state == RUN);
   end

endmodule

// File: tb/tb_programmable_tick_gen.sv
// Directed bench for programmable_tick_gen: a default 4-channel build plus a
// 3-channel, 4-bit free counter build sharing the same stimulus.
module tb_programmable_tick_gen;

   logic        clock;
   logic        reset;
   logic        enable;
   logic        cfgWe;
   logic [1:0]  cfgChan;
   logic [25:0] cfgDiv;
   logic        cfgOneshot;

   logic [3:0]  tick, square, running;
   logic [31:0] freeCount;
   logic [2:0]  tick2, square2, running2;
   logic [3:0]  freeCount2;

   int          checkCount;
   int          failCount;
   logic [31:0] expFree;
   int          tickSeen;

   programmable_tick_gen dut (
      .clock(clock), .reset(reset), .enable(enable),
      .cfg_we(cfgWe), .cfg_chan(cfgChan), .cfg_div(cfgDiv), .cfg_oneshot(cfgOneshot),
      .tick(tick), .square(square), .running(running), .free_count(freeCount)
   );

   programmable_tick_gen #(.CHANNELS(3), .FREE_WIDTH(4)) dut2 (
      .clock(clock), .reset(reset), .enable(enable),
      .cfg_we(cfgWe), .cfg_chan(cfgChan), .cfg_div(cfgDiv), .cfg_oneshot(cfgOneshot),
      .tick(tick2), .square(square2), .running(running2), .free_count(freeCount2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance n edges, tracking the expected free count from the inputs seen at each edge.
   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         if (reset) expFree = '0;
         else if (enable) expFree = expFree + 32'd1;
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [1:0] chan, input logic [25:0] div, input logic oneshot);
      cfgWe      = 1'b1;
      cfgChan    = chan;
      cfgDiv     = div;
      cfgOneshot = oneshot;
      runCycles(1);
      cfgWe      = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      checkCount = 0;
      failCount  = 0;
      expFree    = '0;
      reset      = 1'b1;
      enable     = 1'b1;
      cfgWe      = 1'b1;
      cfgChan    = 2'd0;
      cfgDiv     = 26'd5;
      cfgOneshot = 1'b0;

      // Reset overrides a simultaneous write
      runCycles(2);
      checkOutput("rst_tick", {28'd0, tick}, 32'd0);
      checkOutput("rst_square", {28'd0, square}, 32'd0);
      checkOutput("rst_running", {28'd0, running}, 32'd0);
      checkOutput("rst_free", freeCount, 32'd0);
      checkOutput("rst_free2", {28'd0, freeCount2}, 32'd0);
      reset = 1'b0;
      cfgWe = 1'b0;
      runCycles(2);
      checkOutput("free_after_rst", freeCount, expFree);

      // Periodic D=5 on ch0
      applyStimulus(2'd0, 26'd5, 1'b0);
      checkOutput("a_tick_c0", {31'd0, tick[0]}, 32'd0);
      checkOutput("a_run_c0", {31'd0, running[0]}, 32'd1);
      for (int c = 1; c <= 15; c++) begin
         runCycles(1);
         checkOutput($sformatf("a_tick_c%0d", c), {31'd0, tick[0]}, {31'd0, (c % 5) == 0});
         checkOutput($sformatf("a_sq_c%0d", c), {31'd0, square[0]}, 32'((c / 5) % 2));
      end

      // One-shot D=3 on ch1, then re-arm with D=2
      applyStimulus(2'd1, 26'd3, 1'b1);
      checkOutput("b_tick_c0", {31'd0, tick[1]}, 32'd0);
      checkOutput("b_run_c0", {31'd0, running[1]}, 32'd1);
      runCycles(2);
      checkOutput("b_tick_c2", {31'd0, tick[1]}, 32'd0);
      runCycles(1);
      checkOutput("b_tick_c3", {31'd0, tick[1]}, 32'd1);
      checkOutput("b_run_c3", {31'd0, running[1]}, 32'd0);
      tickSeen = 0;
      for (int c = 0; c < 50; c++) begin
         runCycles(1);
         if (tick[1] || running[1]) tickSeen++;
      end
      checkOutput("b_quiet50", tickSeen, 32'd0);
      checkOutput("b_sq_held", {31'd0, square[1]}, 32'd1);
      applyStimulus(2'd1, 26'd2, 1'b1);
      checkOutput("b2_run_c0", {31'd0, running[1]}, 32'd1);
      checkOutput("b2_sq_c0", {31'd0, square[1]}, 32'd0);
      runCycles(1);
      checkOutput("b2_tick_c1", {31'd0, tick[1]}, 32'd0);
      runCycles(1);
      checkOutput("b2_tick_c2", {31'd0, tick[1]}, 32'd1);

      // Enable freeze with ch0 D=4 at count 2
      applyStimulus(2'd0, 26'd4, 1'b0);
      runCycles(1);
      enable = 1'b0;
      for (int c = 0; c < 7; c++) begin
         runCycles(1);
         checkOutput($sformatf("c_tick_off%0d", c), {28'd0, tick}, 32'd0);
         checkOutput($sformatf("c_free_off%0d", c), freeCount, expFree);
      end
      enable = 1'b1;
      runCycles(1);
      checkOutput("c_tick_on1", {31'd0, tick[0]}, 32'd0);
      runCycles(1);
      checkOutput("c_tick_on2", {31'd0, tick[0]}, 32'd0);
      runCycles(1);
      checkOutput("c_tick_on3", {31'd0, tick[0]}, 32'd1);

      // Write ch2 on the very edge its count is 0
      applyStimulus(2'd2, 26'd3, 1'b0);
      runCycles(2);
      checkOutput("d_tick_pre", {31'd0, tick[2]}, 32'd0);
      applyStimulus(2'd2, 26'd4, 1'b0);
      checkOutput("d_tick_collide", {31'd0, tick[2]}, 32'd0);
      checkOutput("d_sq_collide", {31'd0, square[2]}, 32'd0);
      for (int c = 1; c <= 4; c++) begin
         runCycles(1);
         checkOutput($sformatf("d_tick_c%0d", c), {31'd0, tick[2]}, {31'd0, c == 4});
      end
      checkOutput("d_sq_c4", {31'd0, square[2]}, 32'd1);

      // ch3: D=0 stops, D=1 ticks every cycle
      applyStimulus(2'd3, 26'd0, 1'b0);
      runCycles(2);
      checkOutput("e_d0_run", {31'd0, running[3]}, 32'd0);
      checkOutput("e_d0_tick", {31'd0, tick[3]}, 32'd0);
      applyStimulus(2'd3, 26'd1, 1'b0);
      checkOutput("e_d1_tick_c0", {31'd0, tick[3]}, 32'd0);
      checkOutput("e_d1_sq_c0", {31'd0, square[3]}, 32'd0);
      for (int c = 1; c <= 5; c++) begin
         runCycles(1);
         checkOutput($sformatf("e_d1_tick_c%0d", c), {31'd0, tick[3]}, 32'd1);
         checkOutput($sformatf("e_d1_sq_c%0d", c), {31'd0, square[3]}, 32'(c % 2));
      end

      // Fresh reset; out-of-range channel write on the 3-channel build
      reset = 1'b1;
      runCycles(1);
      reset = 1'b0;
      applyStimulus(2'd3, 26'd1, 1'b0);
      checkOutput("f_oob_run_c0", {29'd0, running2}, 32'd0);
      runCycles(2);
      checkOutput("f_oob_tick", {29'd0, tick2}, 32'd0);
      checkOutput("f_oob_run", {29'd0, running2}, 32'd0);
      checkOutput("f_ch3_tick_wide", {31'd0, tick[3]}, 32'd1);

      // 4-bit free counter wraps 14, 15, 0, 1, ...
      for (int i = 0; i < 16 && expFree[3:0] != 4'd14; i++) runCycles(1);
      checkOutput("g_free2_start", {28'd0, freeCount2}, 32'd14);
      for (int c = 1; c <= 20; c++) begin
         runCycles(1);
         checkOutput($sformatf("g_free2_c%0d", c), {28'd0, freeCount2}, {28'd0, 4'(14 + c)});
      end
      checkOutput("g_free_wide", freeCount, expFree);

      // Reset mid-count clears everything on the next cycle
      reset = 1'b1;
      runCycles(1);
      checkOutput("h_tick", {28'd0, tick}, 32'd0);
      checkOutput("h_square", {28'd0, square}, 32'd0);
      checkOutput("h_running", {28'd0, running}, 32'd0);
      checkOutput("h_free", freeCount, 32'd0);
      checkOutput("h_free2", {28'd0, freeCount2}, 32'd0);
      checkOutput("h_tick2", {29'd0, tick2}, 32'd0);
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
